// File: rtl/turbo_pkg.sv
// Shared constants, FSM encoding and RSC tap helpers for the LTE PCCC turbo encoder.
package turbo_pkg;

   localparam int KMAX       = 6144;
   localparam int KSMALL     = 1056;
   localparam int IDXW       = 13;
   localparam int TAIL_WORDS = 4;
   localparam int TERM_STEPS = 3;

   // RSC state vector: bit 0 is s1 (newest), bit 2 is s3 (oldest).
   localparam logic [2:0] FB_TAPS  = 3'b110;
   localparam logic [2:0] PAR_TAPS = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ENC  = 2'd1,
      ST_TERM = 2'd2,
      ST_TAIL = 2'd3
   } enc_state_t;

   function automatic logic rsc_feedback(input logic [2:0] s);
      return ^(s & FB_TAPS);
   endfunction

   function automatic logic rsc_parity(input logic a, input logic [2:0] s);
      return a ^ (^(s & PAR_TAPS));
   endfunction

   function automatic logic [2:0] rsc_next(input logic a, input logic [2:0] s);
      return {s[1:0], a};
   endfunction

endpackage

// File: rtl/turbo_rsc_core.sv
// One rate-1/2 recursive systematic convolutional constituent encoder (8-state LTE RSC).
// In term mode the input is forced to the feedback so the trellis is driven back to zero.
module turbo_rsc_core
   import turbo_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic advance,
   input  logic term,
   input  logic c,
   output logic x,
   output logic z
);

   logic [2:0] s_q;
   logic       fb;
   logic       a;

   always_comb begin
      fb = rsc_feedback(s_q);
      x  = term ? fb : c;
      a  = x ^ fb;
      z  = rsc_parity(a, s_q);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s_q <= '0;
      end else if (clear) begin
         s_q <= '0;
      end else if (advance) begin
         s_q <= rsc_next(a, s_q);
      end
   end

endmodule

// File: rtl/turbo_pccc_encoder.sv
// LTE PCCC turbo encoder: captures a block and its interleaved copy, streams {z',z,x}
// one word per handshake, then appends the four trellis-termination words.
module turbo_pccc_encoder
   import turbo_pkg::*;
(
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic            k_eq_6144,
   input  logic [KMAX-1:0] blk_in,
   input  logic [KMAX-1:0] blk_intl,
   output logic            ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2:0]      out_d,
   output logic            out_last,
   output logic            busy
);

   enc_state_t      state_q;
   enc_state_t      state_d;
   logic [KMAX-1:0] blk_q;
   logic [KMAX-1:0] intl_q;
   logic            k_big_q;
   logic [IDXW-1:0] idx_q;
   logic [IDXW-1:0] last_idx;
   logic [1:0]      term_cnt_q;
   logic [2:0]      tail_cnt_q;
   logic [2:0]      t1x_q;
   logic [2:0]      t1z_q;
   logic [2:0]      t2x_q;
   logic [2:0]      t2z_q;
   logic            out_valid_q;
   logic            out_last_q;
   logic [2:0]      out_d_q;
   logic [2:0]      tail_word;

   logic accept_start;
   logic can_load;
   logic enc_load;
   logic tail_load;
   logic in_term;
   logic rsc_adv;
   logic c1;
   logic c2;
   logic x1;
   logic z1;
   logic x2;
   logic z2;

   assign can_load = !out_valid_q || out_ready;
   assign in_term  = (state_q == ST_TERM);
   assign rsc_adv  = enc_load || in_term;
   assign last_idx = k_big_q ? IDXW'(KMAX - 1) : IDXW'(KSMALL - 1);
   assign c1       = blk_q[idx_q];
   assign c2       = intl_q[idx_q];

   turbo_rsc_core u_rsc1 (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (accept_start),
      .advance (rsc_adv),
      .term    (in_term),
      .c       (c1),
      .x       (x1),
      .z       (z1)
   );

   turbo_rsc_core u_rsc2 (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (accept_start),
      .advance (rsc_adv),
      .term    (in_term),
      .c       (c2),
      .x       (x2),
      .z       (z2)
   );

   always_comb begin
      state_d      = state_q;
      accept_start = 1'b0;
      enc_load     = 1'b0;
      tail_load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept_start = 1'b1;
               state_d      = ST_ENC;
            end
         end
         ST_ENC: begin
            if (can_load) begin
               enc_load = 1'b1;
               if (idx_q == last_idx) begin
                  state_d = ST_TERM;
               end
            end
         end
         ST_TERM: begin
            if (term_cnt_q == 2'(TERM_STEPS - 1)) begin
               state_d = ST_TAIL;
            end
         end
         ST_TAIL: begin
            // Once all tail words are loaded, leave only when the last one is taken.
            if (tail_cnt_q != 3'(TAIL_WORDS)) begin
               tail_load = can_load;
            end else if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      case (tail_cnt_q[1:0])
         2'd0:    tail_word = {t1x_q[1], t1z_q[0], t1x_q[0]};
         2'd1:    tail_word = {t1z_q[2], t1x_q[2], t1z_q[1]};
         2'd2:    tail_word = {t2x_q[1], t2z_q[0], t2x_q[0]};
         default: tail_word = {t2z_q[2], t2x_q[2], t2z_q[1]};
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         k_big_q    <= 1'b0;
         term_cnt_q <= '0;
         tail_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept_start) begin
            idx_q   <= '0;
            k_big_q <= k_eq_6144;
         end else if (enc_load) begin
            idx_q <= idx_q + 1'b1;
         end
         term_cnt_q <= in_term ? term_cnt_q + 2'd1 : 2'd0;
         if (state_q != ST_TAIL) begin
            tail_cnt_q <= '0;
         end else if (tail_load) begin
            tail_cnt_q <= tail_cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         blk_q  <= '0;
         intl_q <= '0;
      end else if (accept_start) begin
         blk_q  <= blk_in;
         intl_q <= blk_intl;
      end
   end

   // Termination outputs are collected here and replayed in the 36.212 tail order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         t1x_q <= '0;
         t1z_q <= '0;
         t2x_q <= '0;
         t2z_q <= '0;
      end else if (in_term) begin
         t1x_q[term_cnt_q] <= x1;
         t1z_q[term_cnt_q] <= z1;
         t2x_q[term_cnt_q] <= x2;
         t2z_q[term_cnt_q] <= z2;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_d_q     <= '0;
         out_last_q  <= 1'b0;
      end else if (enc_load) begin
         out_valid_q <= 1'b1;
         out_d_q     <= {z2, z1, x1};
         out_last_q  <= 1'b0;
      end else if (tail_load) begin
         out_valid_q <= 1'b1;
         out_d_q     <= tail_word;
         out_last_q  <= (tail_cnt_q == 3'(TAIL_WORDS - 1));
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end
   end

   assign ready     = (state_q == ST_IDLE);
   assign busy      = !ready;
   assign out_valid = out_valid_q;
   assign out_d     = out_d_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_turbo_pccc_encoder.sv
// Scoreboard bench for turbo_pccc_encoder: a polynomial-form RSC model and a QPP
// interleaver fill an expected-word queue that a free-running monitor drains.
module tb_turbo_pccc_encoder;
   import turbo_pkg::*;

   logic            clock;
   logic            reset_n;
   logic            start;
   logic            k_eq_6144;
   logic [KMAX-1:0] blk_in;
   logic [KMAX-1:0] blk_intl;
   logic            ready;
   logic            out_valid;
   logic            out_ready;
   logic [2:0]      out_d;
   logic            out_last;
   logic            busy;

   typedef struct {
      logic [2:0] d;
      logic       last;
      int         k;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   failures = 0;
   int   blk_words = 0;
   bit   rand_ready = 0;
   bit   check_ready_next = 0;
   logic [KMAX-1:0] blk3;

   turbo_pccc_encoder dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .k_eq_6144 (k_eq_6144),
      .blk_in    (blk_in),
      .blk_intl  (blk_intl),
      .ready     (ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_d     (out_d),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: actual %0h, required %0h", name, act, req);
      end
   endtask

   // Parity as a polynomial recursion on the feedback sequence a_n:
   // a_n = c_n ^ a_{n-2} ^ a_{n-3}, z_n = a_n ^ a_{n-1} ^ a_{n-3}; av[m+3] holds a_m.
   function automatic void rsc_model(input logic [KMAX-1:0] c, input int k,
                                     output bit par[KMAX], output bit tx[3], output bit tz[3]);
      bit av[$];
      bit an;
      int m;
      av = '{1'b0, 1'b0, 1'b0};
      for (int n = 0; n < k; n++) begin
         an = c[n] ^ av[n+1] ^ av[n];
         av.push_back(an);
         par[n] = an ^ av[n+2] ^ av[n];
      end
      for (int j = 0; j < 3; j++) begin
         m     = k + j;
         tx[j] = av[m+1] ^ av[m];
         tz[j] = av[m+2] ^ av[m];
         av.push_back(1'b0);
      end
   endfunction

   function automatic logic [KMAX-1:0] qpp(input logic [KMAX-1:0] c, input int k);
      logic [KMAX-1:0] r;
      longint f1;
      longint f2;
      longint pi;
      f1 = (k == 6144) ? 263 : 17;
      f2 = (k == 6144) ? 480 : 66;
      r  = '0;
      for (int i = 0; i < k; i++) begin
         pi   = (f1 * i + f2 * longint'(i) * i) % k;
         r[i] = c[int'(pi)];
      end
      return r;
   endfunction

   function automatic logic [KMAX-1:0] rand_block();
      logic [KMAX-1:0] r;
      for (int w = 0; w < KMAX / 32; w++) r[w*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic push_word(input logic [2:0] d, input logic last, input int k);
      exp_t e;
      e.d    = d;
      e.last = last;
      e.k    = k;
      exp_q.push_back(e);
   endtask

   task automatic push_expected(input logic [KMAX-1:0] c, input logic [KMAX-1:0] cp, input int k);
      bit p1[KMAX];
      bit p2[KMAX];
      bit x1[3];
      bit z1[3];
      bit x2[3];
      bit z2[3];
      rsc_model(c, k, p1, x1, z1);
      rsc_model(cp, k, p2, x2, z2);
      for (int i = 0; i < k; i++) push_word({p2[i], p1[i], c[i]}, 1'b0, k);
      push_word({x1[1], z1[0], x1[0]}, 1'b0, k);
      push_word({z1[2], x1[2], z1[1]}, 1'b0, k);
      push_word({x2[1], z2[0], x2[0]}, 1'b0, k);
      push_word({z2[2], x2[2], z2[1]}, 1'b1, k);
   endtask

   task automatic apply_stimulus(input logic [KMAX-1:0] c, input bit big);
      int k;
      int waited;
      logic [KMAX-1:0] cp;
      k      = big ? KMAX : KSMALL;
      cp     = qpp(c, k);
      waited = 0;
      while (!ready && waited < 20000) begin
         @(posedge clock);
         #1 waited++;
      end
      if (!ready) begin
         check_output("ready_timeout", 32'(ready), 32'd1);
      end else begin
         blk_in    = c;
         blk_intl  = cp;
         k_eq_6144 = big;
         start     = 1'b1;
         push_expected(c, cp, k);
         @(posedge clock);
         #1 start = 1'b0;
         @(negedge clock);
         check_output("latency_edge1_valid", 32'(out_valid), 32'd0);
         @(negedge clock);
         check_output("latency_edge2_valid", 32'(out_valid), 32'd1);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(ready && exp_q.size() == 0) && n < 40000) begin
         @(negedge clock);
         n++;
      end
      check_output("drain_ready", 32'(ready), 32'd1);
      check_output("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: compare every presented word against the queue head; pop on handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset_n) begin
            if (check_ready_next) begin
               check_output("ready_after_last", 32'(ready), 32'd1);
               check_ready_next = 0;
            end
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  check_output("unexpected_word_pending", 32'd0, 32'd1);
               end else begin
                  check_output("out_d", 32'(out_d), 32'(exp_q[0].d));
                  check_output("out_last", 32'(out_last), 32'(exp_q[0].last));
                  if (out_ready) begin
                     e = exp_q.pop_front();
                     blk_words++;
                     if (e.last) begin
                        check_output("block_word_count", 32'(blk_words), 32'(e.k + TAIL_WORDS));
                        blk_words        = 0;
                        check_ready_next = 1;
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      logic [KMAX-1:0] b;
      int n;
      reset_n   = 1'b0;
      start     = 1'b0;
      k_eq_6144 = 1'b0;
      blk_in    = '0;
      blk_intl  = '0;
      #12;
      check_output("reset_ready", 32'(ready), 32'd1);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_out_valid", 32'(out_valid), 32'd0);
      check_output("reset_out_d", 32'(out_d), 32'd0);
      check_output("reset_out_last", 32'(out_last), 32'd0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      $display("[TB] all-zero block, K=1056");
      apply_stimulus('0, 1'b0);
      wait_idle();

      $display("[TB] single-one block, K=1056");
      b    = '0;
      b[0] = 1'b1;
      apply_stimulus(b, 1'b0);
      wait_idle();

      $display("[TB] random block, K=6144");
      blk3 = rand_block();
      apply_stimulus(blk3, 1'b1);
      wait_idle();

      $display("[TB] same block with random backpressure");
      rand_ready = 1;
      apply_stimulus(blk3, 1'b1);
      wait_idle();
      rand_ready = 0;

      $display("[TB] reset in the middle of a K=6144 block");
      apply_stimulus(rand_block(), 1'b1);
      n = 0;
      while (blk_words < 500 && n < 2000) begin
         @(posedge clock);
         n++;
      end
      check_output("reached_word_500", 32'(blk_words >= 500), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check_output("midreset_out_valid", 32'(out_valid), 32'd0);
      check_output("midreset_ready", 32'(ready), 32'd1);
      check_output("midreset_busy", 32'(busy), 32'd0);
      exp_q.delete();
      blk_words        = 0;
      check_ready_next = 0;
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      @(posedge clock);
      #1;
      apply_stimulus(rand_block(), 1'b0);
      wait_idle();

      $display("[TB] start during encoding, then back-to-back blocks");
      apply_stimulus(rand_block(), 1'b0);
      @(posedge clock);
      #1;
      check_output("busy_during_enc", 32'(busy), 32'd1);
      blk_in = rand_block();
      start  = 1'b1;
      repeat (4) @(posedge clock);
      #1 start = 1'b0;
      apply_stimulus(rand_block(), 1'b0);
      wait_idle();
      repeat (10) @(negedge clock);
      check_output("idle_no_stray_output", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
